serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around the existing single-bit full_adder cell.
//  Loads two operands and a carry-in. Feeds one bit pair per clock, LSB first, through
//  one full_adder instance. The carry is held in a flip-flop between bits.
//  Downstream consumer of full_adder: trades WIDTH cycles of latency for one adder cell.
//  Used where area matters more than throughput.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 1..32
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  a_in      in   WIDTH  operand A, captured on accepted start
//  b_in      in   WIDTH  operand B, captured on accepted start
//  cin_in    in   1      initial carry, captured on accepted start
//  busy      out  1      high while in SHIFT
//  done      out  1      one-cycle pulse: result valid
//  sum_out   out  WIDTH  result; holds value until next accepted start
//  cout_out  out  1      final carry-out; holds with sum_out
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum_out=0, cout_out=0.
//    Internal shift registers, carry FF and bit counter are cleared.
//    Reset mid-SHIFT aborts the add; no done pulse is produced.
//  - FSM states IDLE, SHIFT, DONE:
//      IDLE : start=1 at edge k -> load a_sr=a_in, b_sr=b_in, carry=cin_in, cnt=0; go SHIFT.
//             start=0 -> stay in IDLE.
//      SHIFT: each edge: full_adder(a=a_sr[0], b=b_sr[0], cin=carry);
//             carry<=count; shift a_sr and b_sr right by 1;
//             shift sum bit into the result register from the MSB end; cnt<=cnt+1.
//             On the edge where cnt==WIDTH-1 (edge k+WIDTH), go DONE.
//             At that same edge, sum_out and cout_out update with the final result.
//      DONE : done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
//  - Latency: start accepted at edge k; done high in the cycle following edge k+WIDTH.
//    Back-to-back adds: next start is accepted no earlier than edge k+WIDTH+2.
//  - start is ignored in SHIFT and DONE. It is not queued; no error is flagged.
//  - a_in, b_in and cin_in are don't-care except at the accepting edge.
//  - sum_out/cout_out update only at the edge entering DONE. They are stable otherwise,
//    including throughout SHIFT, so the previous result stays readable.
//    Use a separate shift register internally; publish to sum_out only on entering DONE.
//  - Arithmetic: {cout_out,sum_out} == a_in + b_in + cin_in, computed modulo 2^(WIDTH+1).
//  - Counter width is $clog2(WIDTH)+1 so WIDTH=1 and powers of two do not wrap early.
//  - Outputs are registered; busy and done are decoded from the state register.
// STRUCTURE
//  - Shared package/include: FSM state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1,
//    ST_DONE=2'd2), and a SERIAL_ADD_LAT = WIDTH+1 helper for benches.
//  - Sub-module: exactly one full_adder instance.
//    Ports .a .b .cin .sum .count, where count is the carry-out.
//  - No other hierarchy. FSM, shift registers and counter live in this module.
// TESTING  (WIDTH=8 unless stated; check at the done pulse)
//  1. rst held 3 cycles, then released -> busy=0, done=0, sum_out=8'h00, cout_out=0.
//  2. a=8'h3C, b=8'h42, cin=0, start -> done exactly 9 cycles after accept;
//     sum_out=8'h7E, cout=0.
//  3. a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout=1.
//     a=8'hA5, b=8'h5A, cin=1 -> sum_out=8'h00, cout=1 (full carry ripple).
//  4. start pulsed again at SHIFT cycle 3 with different operands -> ignored;
//     result matches the first operands; sum_out unchanged during SHIFT.
//  5. rst asserted at SHIFT cycle 4 -> next cycle IDLE, outputs 0, no done pulse.
//     A fresh start then completes normally.
//  6. WIDTH=1: a=1, b=1, cin=1 -> done 2 cycles after accept; sum_out=1'b1, cout=1.
//  Plus: a 500-vector random self-check against a+b+cin, with back-to-back starts.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a latency helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Edges from the accepting edge until the edge that leaves DONE.
  function automatic int unsigned serial_add_lat(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; master drives operands, slave computes.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell; count is the carry-out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = a ^ b ^ cin;
  assign count = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, carry held in a flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fa_sum, fa_cout;
  logic [WIDTH-1:0]  res_shift;

  full_adder u_full_adder (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .count(fa_cout)
  );

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = fa_sum;
  end else begin : g_res_wn
    assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_sr_d  = bus.a_in;
          b_sr_d  = bus.b_in;
          carry_d = bus.cin_in;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        carry_d = fa_cout;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = res_shift;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = ST_DONE;
          sum_d   = res_shift;
          cout_d  = fa_cout;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random back-to-back adds.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] last_sum;
  logic         last_cout;

  // One add on the WIDTH=8 instance; pulse_at >= 0 re-pulses start mid-SHIFT.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int pulse_at, input string tag);
    logic [W:0] expected;
    bit         accepted;
    bit         stable;
    int         n;
    expected = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    bus8.start  = 1'b1;
    bus8.a_in   = a;
    bus8.b_in   = b;
    bus8.cin_in = cin;
    accepted = 1'b0;
    for (int i = 0; i < 2 * W + 8; i++) begin
      @(posedge clk); #1;
      if (bus8.busy === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    bus8.start  = 1'b0;
    bus8.a_in   = W'($urandom);
    bus8.b_in   = W'($urandom);
    bus8.cin_in = 1'($urandom);
    vectors++;
    if (!accepted) begin
      miscompares++;
      $display("FAIL %s accept: busy=%b required 1", tag, bus8.busy);
      return;
    end
    n = 0;
    stable = 1'b1;
    while (bus8.done !== 1'b1 && n < 4 * W) begin
      if (bus8.sum_out !== last_sum || bus8.cout_out !== last_cout) stable = 1'b0;
      if (n == pulse_at) begin
        bus8.start  = 1'b1;
        bus8.a_in   = ~a;
        bus8.b_in   = ~b;
        bus8.cin_in = ~cin;
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus8.start = 1'b0;
    vectors++;
    if (bus8.done !== 1'b1 || n != int'(serial_add_lat(W)) - 1) begin
      miscompares++;
      $display("FAIL %s latency: done=%b after %0d edges, required %0d", tag, bus8.done, n,
               serial_add_lat(W) - 1);
    end
    vectors++;
    if ({bus8.cout_out, bus8.sum_out} !== expected) begin
      miscompares++;
      $display("FAIL %s result: a=%h b=%h cin=%b got cout=%b sum=%h required cout=%b sum=%h",
               tag, a, b, cin, bus8.cout_out, bus8.sum_out, expected[W], expected[W-1:0]);
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL %s hold: sum_out/cout_out changed during SHIFT, required %h/%b", tag,
               last_sum, last_cout);
    end
    vectors++;
    if (bus8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_at_done: got %b required 0", tag, bus8.busy);
    end
    last_sum  = expected[W-1:0];
    last_cout = expected[W];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.cin_in = 1'b0;
    bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus8.busy, bus8.done, bus8.cout_out} !== 3'b000 || bus8.sum_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b required all zero", bus8.busy,
               bus8.done, bus8.sum_out, bus8.cout_out);
    end
    vectors++;
    if ({bus1.busy, bus1.done, bus1.cout_out, bus1.sum_out} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset1: busy=%b done=%b sum=%b cout=%b required all zero", bus1.busy,
               bus1.done, bus1.sum_out, bus1.cout_out);
    end
    last_sum  = '0;
    last_cout = 1'b0;
  endtask

  task automatic test_directed();
    run_add(8'h3C, 8'h42, 1'b0, -1, "add_3c_42");
    @(posedge clk); #1;
    vectors++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: done=%b busy=%b one cycle later, required 0/0", bus8.done,
               bus8.busy);
    end
    run_add(8'hFF, 8'h01, 1'b0, -1, "add_ff_01");
    run_add(8'hA5, 8'h5A, 1'b1, -1, "add_a5_5a_c");
  endtask

  task automatic test_ignore_start();
    run_add(8'h11, 8'h22, 1'b0, 3, "ignore_start");
  endtask

  task automatic test_reset_mid();
    bit accepted;
    bit saw_done;
    bus8.start = 1'b1; bus8.a_in = 8'h77; bus8.b_in = 8'h19; bus8.cin_in = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 2 * W + 8; i++) begin
      @(posedge clk); #1;
      if (bus8.busy === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (!accepted || {bus8.busy, bus8.done, bus8.cout_out} !== 3'b000 ||
        bus8.sum_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: accepted=%b busy=%b done=%b sum=%h cout=%b required all zero",
               accepted, bus8.busy, bus8.done, bus8.sum_out, bus8.cout_out);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (bus8.done !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL reset_mid_done: done pulsed after abort, required none");
    end
    last_sum  = '0;
    last_cout = 1'b0;
    run_add(8'h77, 8'h19, 1'b1, -1, "after_abort");
  endtask

  task automatic test_width1();
    logic [1:0] expected;
    logic       a, b, c;
    int         n;
    for (int v = 7; v >= 0; v--) begin
      a = v[2]; b = v[1]; c = v[0];
      expected = {1'b0, a} + {1'b0, b} + {1'b0, c};
      bus1.start = 1'b1; bus1.a_in = a; bus1.b_in = b; bus1.cin_in = c;
      n = 0;
      while (bus1.busy !== 1'b1 && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      bus1.start = 1'b0;
      n = 0;
      while (bus1.done !== 1'b1 && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      vectors++;
      if (bus1.done !== 1'b1 || n != int'(serial_add_lat(1)) - 1 ||
          {bus1.cout_out, bus1.sum_out} !== expected) begin
        miscompares++;
        $display("FAIL width1 %b+%b+%b: done=%b edges=%0d cout=%b sum=%b required edges=1 %b/%b",
                 a, b, c, bus1.done, n, bus1.cout_out, bus1.sum_out, expected[1], expected[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2 * W)),
              "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_width1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
